// File: rtl/eth_tx_arb_pkg.sv
// eth_tx_arb_pkg: shared FSM type and PTP tag field layout for the TX arbiter
package eth_tx_arb_pkg;
  typedef enum logic {IDLE, XFER} state_t;
  localparam int USER_W = 17;
  localparam int TAG_W = 16;
  localparam int SEQ_W = 8;
  localparam int PORT_TAG_W = 8;
  localparam int TAG_LSB = 1;
  localparam int SEQ_OFF = 0;
  localparam int PORT_OFF = SEQ_W;
endpackage

// File: rtl/eth_rr_pick.sv
// eth_rr_pick: combinational round-robin picker, first requester at or after ptr wins
module eth_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [7:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [7:0]   idx,
  output logic         vld
);
  always_comb begin
    int best;
    best = N;
    gnt = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && ((i - int'(ptr) + N) % N) < best) begin
        best = (i - int'(ptr) + N) % N;
        idx = 8'(i);
        gnt = '0;
        gnt[i] = 1'b1;
      end
    end
    vld = best < N;
  end
endmodule

// File: rtl/eth_tx_ptp_arbiter.sv
// eth_tx_ptp_arbiter: frame round-robin MAC TX arbiter with PTP tag stamping and timestamp return (ETH_TX_ARB_PTP_TAG_EN)
module eth_tx_ptp_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int TS_W = 96
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N*DATA_W-1:0]   s_axis_tdata,
  input  logic [N*KEEP_W-1:0]   s_axis_tkeep,
  input  logic [N-1:0]          s_axis_tlast,
  input  logic [N*USER_W-1:0]   s_axis_tuser,
  input  logic [N-1:0]          s_axis_tvalid,
  output logic [N-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [KEEP_W-1:0]     m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [USER_W-1:0]     m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic [TS_W-1:0]       s_ptp_ts,
  input  logic [TAG_W-1:0]      s_ptp_ts_tag,
  input  logic                  s_ptp_ts_valid,
  output logic [N*TS_W-1:0]     m_ptp_ts,
  output logic [N*TAG_W-1:0]    m_ptp_ts_tag,
  output logic [N-1:0]          m_ptp_ts_valid,
  output logic [7:0]            grant_port
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  state_t state, nxt;
  logic [7:0] g, ptr, idx;
  logic [N-1:0] g_oh, pick_oh;
  logic vld, xfer, eof;
  logic [IW-1:0] gi;
  logic [USER_W-1:0] user_out;

  eth_rr_pick #(.N(N)) u_pick (
    .req (s_axis_tvalid),
    .ptr (ptr),
    .gnt (pick_oh),
    .idx (idx),
    .vld (vld)
  );

  assign gi = g[IW-1:0];
  assign xfer = state == XFER;
  assign eof = xfer && s_axis_tvalid[gi] && m_axis_tready && s_axis_tlast[gi];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    nxt = xfer ? (eof ? IDLE : XFER) : (vld ? XFER : IDLE);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      g <= '0;
      g_oh <= '0;
      ptr <= '0;
    end else begin
      if (!xfer && vld) begin
        g <= idx;
        g_oh <= pick_oh;
      end
      if (eof) ptr <= g == 8'(N - 1) ? '0 : g + 8'd1;
    end

  assign grant_port = g;
  assign s_axis_tready = xfer && m_axis_tready ? g_oh : '0;
  assign m_axis_tvalid = xfer && s_axis_tvalid[gi];
  assign m_axis_tdata = xfer ? s_axis_tdata[gi*DATA_W +: DATA_W] : '0;
  assign m_axis_tkeep = xfer ? s_axis_tkeep[gi*KEEP_W +: KEEP_W] : '0;
  assign m_axis_tlast = xfer && s_axis_tlast[gi];
  assign m_axis_tuser = xfer ? user_out : '0;

`ifdef ETH_TX_ARB_PTP_TAG_EN
  logic [SEQ_W-1:0] seq [N];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) seq[i] <= '0;
    end else if (eof) begin
      seq[gi] <= seq[gi] + 1'b1;
    end

  assign user_out = {g[PORT_TAG_W-1:0], seq[gi], s_axis_tuser[gi*USER_W]};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_ptp_ts <= '0;
      m_ptp_ts_tag <= '0;
      m_ptp_ts_valid <= '0;
    end else begin
      m_ptp_ts_valid <= '0;
      for (int i = 0; i < N; i++) begin
        if (s_ptp_ts_valid && s_ptp_ts_tag[TAG_W-1:PORT_OFF] == 8'(i)) begin
          m_ptp_ts[i*TS_W +: TS_W] <= s_ptp_ts;
          m_ptp_ts_tag[i*TAG_W +: TAG_W] <= {8'h00, s_ptp_ts_tag[PORT_OFF-1:SEQ_OFF]};
          m_ptp_ts_valid[i] <= 1'b1;
        end
      end
    end
`else
  logic unused_ts;
  assign unused_ts = ^{s_ptp_ts, s_ptp_ts_tag, s_ptp_ts_valid};
  assign user_out = s_axis_tuser[gi*USER_W +: USER_W];
  assign m_ptp_ts = '0;
  assign m_ptp_ts_tag = '0;
  assign m_ptp_ts_valid = '0;
`endif
endmodule

// File: tb/tb_eth_tx_ptp_arbiter.sv
// tb_eth_tx_ptp_arbiter: randomized frame scoreboard bench for the TX PTP arbiter
module tb_eth_tx_ptp_arbiter;
  localparam int N = 2;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int TW = 96;
  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic l;
    logic [16:0] u;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*DW-1:0] s_tdata = '0;
  logic [N*KW-1:0] s_tkeep = '0;
  logic [N-1:0] s_tlast = '0;
  logic [N*17-1:0] s_tuser = '0;
  logic [N-1:0] s_tvalid = '0;
  logic [N-1:0] s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic m_tlast;
  logic [16:0] m_tuser;
  logic m_tvalid;
  logic m_tready = 1'b1;
  logic [TW-1:0] ts = '0;
  logic [15:0] ts_tag = '0;
  logic ts_valid = 1'b0;
  logic [N*TW-1:0] m_ts;
  logic [N*16-1:0] m_ts_tag;
  logic [N-1:0] m_ts_valid;
  logic [7:0] grant_port;
  beat_t q [N][$];
  int vpct [N];
  int vlow [N];
  int rpct = 100;
  int rdy_low = 0;
  bit ts_auto = 1'b0;
  bit ts_once = 1'b0;
  logic [15:0] ts_o_tag = '0;
  logic [TW-1:0] ts_o_val = '0;
  int nfr [N];
  int cur = -1;
  bit bubble = 1'b0;
  int gq [$];
  logic [N-1:0] hs = '0;
  logic [N-1:0] exp_v = '0;
  logic [TW-1:0] exp_ts [N];
  logic [15:0] exp_tag [N];
  int total = 0;
  int bad = 0;
  int fid = 0;

  eth_tx_ptp_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_tdata   (s_tdata),
    .s_axis_tkeep   (s_tkeep),
    .s_axis_tlast   (s_tlast),
    .s_axis_tuser   (s_tuser),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tlast   (m_tlast),
    .m_axis_tuser   (m_tuser),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .s_ptp_ts       (ts),
    .s_ptp_ts_tag   (ts_tag),
    .s_ptp_ts_valid (ts_valid),
    .m_ptp_ts       (m_ts),
    .m_ptp_ts_tag   (m_ts_tag),
    .m_ptp_ts_valid (m_ts_valid),
    .grant_port     (grant_port)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_frame(int p, int len, logic [16:0] u);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = {8'(p), 24'(fid), 32'(i)};
      b.k = 8'($urandom);
      b.l = i == len - 1;
      b.u = u;
      q[p].push_back(b);
    end
    fid++;
  endtask

  function automatic bit busy();
    bit r;
    r = cur >= 0;
    for (int i = 0; i < N; i++) r = r || q[i].size() > 0;
    return r;
  endfunction

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 128'(n >= budget), 0);
    #1;
  endtask

  task automatic drive();
    int tp;
    for (int p = 0; p < N; p++) begin
      if (hs[p]) void'(q[p].pop_front());
      if (q[p].size() > 0) begin
        s_tdata[p*DW +: DW] = q[p][0].d;
        s_tkeep[p*KW +: KW] = q[p][0].k;
        s_tlast[p] = q[p][0].l;
        s_tuser[p*17 +: 17] = q[p][0].u;
        s_tvalid[p] = vlow[p] == 0 && $urandom_range(99) < 32'(vpct[p]);
      end else begin
        s_tvalid[p] = 1'b0;
      end
      if (vlow[p] > 0) vlow[p]--;
    end
    m_tready = rdy_low == 0 && $urandom_range(99) < 32'(rpct);
    if (rdy_low > 0) rdy_low--;
    if (ts_once) begin
      ts_valid = 1'b1;
      ts_tag = ts_o_tag;
      ts = ts_o_val;
      ts_once = 1'b0;
    end else if (ts_auto && $urandom_range(99) < 30) begin
      tp = $urandom_range(3);
      ts_valid = 1'b1;
      ts_tag = {8'(tp), 8'($urandom)};
      ts = {$urandom, $urandom, $urandom};
    end else begin
      ts_valid = 1'b0;
    end
  endtask

  task automatic monitor();
    int p;
    int np;
    int tp;
    logic [16:0] eu;
    if (!rst_n) begin
      hs = '0;
      cur = -1;
      bubble = 1'b0;
      exp_v = '0;
      for (int i = 0; i < N; i++) begin
        nfr[i] = 0;
        exp_ts[i] = '0;
        exp_tag[i] = '0;
      end
      return;
    end
    hs = s_tvalid & s_tready;
    np = $countones(hs);
    p = -1;
    for (int i = 0; i < N; i++) if (hs[i]) p = i;
    chk("rdy_onehot", 128'($countones(s_tready) > 1), 0);
    if (bubble) chk("bubble", m_tvalid, 0);
    bubble = 1'b0;
    if (cur >= 0) begin
      chk("vpass", m_tvalid, s_tvalid[cur]);
      chk("rdy_other", s_tready & ~(N'(1) << cur), 0);
    end
    if (np > 0 || (m_tvalid && m_tready)) chk("hs_pair", m_tvalid && m_tready, np == 1);
    if (m_tvalid && m_tready && p >= 0) begin
      if (cur < 0) begin
        chk("grant", grant_port, p);
        gq.push_back(p);
      end else begin
        chk("atomic", p, cur);
      end
      cur = p;
`ifdef ETH_TX_ARB_PTP_TAG_EN
      eu = {8'(p), 8'(nfr[p]), q[p][0].u[0]};
`else
      eu = q[p][0].u;
`endif
      chk("beat", {m_tdata, m_tkeep, m_tlast}, {q[p][0].d, q[p][0].k, q[p][0].l});
      chk("tuser", m_tuser, eu);
      if (q[p][0].l) begin
        nfr[p]++;
        cur = -1;
        bubble = 1'b1;
      end
    end
    chk("ts_valid", m_ts_valid, exp_v);
    for (int i = 0; i < N; i++) begin
      chk("ts_value", m_ts[i*TW +: TW], exp_ts[i]);
      chk("ts_tag", m_ts_tag[i*16 +: 16], exp_tag[i]);
    end
    exp_v = '0;
`ifdef ETH_TX_ARB_PTP_TAG_EN
    tp = int'(ts_tag[15:8]);
    if (ts_valid && tp < N) begin
      exp_v[tp] = 1'b1;
      exp_ts[tp] = ts;
      exp_tag[tp] = {8'h00, ts_tag[7:0]};
    end
`else
    tp = 0;
`endif
  endtask

  initial forever begin
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  end

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      vpct[i] = 100;
      vlow[i] = 0;
      nfr[i] = 0;
      exp_ts[i] = '0;
      exp_tag[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_grant", grant_port, 0);
    chk("rst_tuser", m_tuser, 0);
    chk("rst_tsvalid", m_ts_valid, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      add_frame(0, 3, 17'($urandom));
      add_frame(1, 3, 17'($urandom));
    end
    wait_idle(300);
    chk("rr_count", gq.size(), 8);
    foreach (gq[i]) chk("rr_order", gq[i], i % 2);
    gq.delete();
    for (int i = 0; i < 257; i++) add_frame(1, 1, 17'($urandom));
    wait_idle(1500);
    add_frame(0, 8, 17'($urandom));
    add_frame(1, 4, 17'($urandom));
    n = 0;
    while (cur != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_start", cur, 0);
    #1 rdy_low = 5;
    repeat (6) @(negedge clk);
    chk("stall_grant", grant_port, 0);
    chk("stall_rdy1", s_tready[1], 0);
    #1 vlow[0] = 2;
    repeat (3) @(negedge clk);
    chk("stall_grant2", grant_port, 0);
    chk("stall_rdy1b", s_tready[1], 0);
    wait_idle(200);
    ts_o_tag = 16'h0105;
    ts_o_val = 96'h1234;
    ts_once = 1'b1;
    repeat (2) @(negedge clk);
`ifdef ETH_TX_ARB_PTP_TAG_EN
    chk("ts_strobe", m_ts_valid, 2'b10);
    chk("ts_port1", m_ts[TW +: TW], 96'h1234);
    chk("ts_tag1", m_ts_tag[16 +: 16], 16'h0005);
`else
    chk("ts_strobe", m_ts_valid, 0);
`endif
    #1;
    ts_o_tag = 16'h0705;
    ts_o_val = 96'hbeef;
    ts_once = 1'b1;
    repeat (2) @(negedge clk);
    chk("ts_drop", m_ts_valid, 0);
`ifdef ETH_TX_ARB_PTP_TAG_EN
    chk("ts_hold", m_ts[TW +: TW], 96'h1234);
`endif
    #1 add_frame(0, 6, 17'($urandom));
    n = 0;
    while (cur != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_start", cur, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tvalid", m_tvalid, 0);
    chk("rst_mid_tready", s_tready, 0);
    chk("rst_mid_tdata", m_tdata, 0);
    chk("rst_mid_grant", grant_port, 0);
    for (int p = 0; p < N; p++) q[p].delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1 add_frame(0, 2, 17'h0abcd);
    wait_idle(100);
    vpct[0] = 70;
    vpct[1] = 70;
    rpct = 70;
    ts_auto = 1'b1;
    for (int i = 0; i < 200; i++) add_frame(int'($urandom_range(N - 1)), int'($urandom_range(6, 1)), 17'($urandom));
    wait_idle(6000);
    ts_auto = 1'b0;
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eth_tx_ptp_arbiter.md
Name: eth_tx_ptp_arbiter

Overview:
Frame-level round-robin arbiter that shares one Ethernet MAC TX AXI-stream (64-bit data, 8-bit keep, 17-bit user) between N requesters. It stamps each granted frame with a PTP tag of the form {port, sequence} in tuser[16:1]. Completion timestamps returned by the MAC (ts, tag, valid) are demultiplexed back to the requester that originated the frame. The block sits between the per-queue TX logic and the MAC model/IP TX interface.

Parameters:
N, 2, number of requester ports (1..16)
DATA_W, 64, AXI-stream data width
KEEP_W, DATA_W/8, tkeep width
TS_W, 96, PTP timestamp width

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  reset; asynchronous assert, active-low
s_axis_tdata  in  N*DATA_W  per-port frame data, port p at [p*DATA_W +: DATA_W]
s_axis_tkeep  in  N*KEEP_W  per-port byte enables
s_axis_tlast  in  N  per-port end of frame
s_axis_tuser  in  N*17  per-port user; bit0 = bad-frame flag, bits[16:1] = requester tag
s_axis_tvalid  in  N  per-port valid
s_axis_tready  out  N  per-port ready
m_axis_tdata  out  DATA_W  to MAC tx_axis_tdata
m_axis_tkeep  out  KEEP_W  to MAC
m_axis_tlast  out  1  to MAC
m_axis_tuser  out  17  to MAC; bit0 = bad frame, [16:1] = PTP tag
m_axis_tvalid  out  1  to MAC
m_axis_tready  in  1  from MAC
s_ptp_ts  in  TS_W  MAC TX timestamp
s_ptp_ts_tag  in  16  tag of the timestamped frame
s_ptp_ts_valid  in  1  single-cycle timestamp strobe
m_ptp_ts  out  N*TS_W  per-port returned timestamp
m_ptp_ts_tag  out  N*16  per-port returned tag, {8'h00, seq}
m_ptp_ts_valid  out  N  per-port strobe
grant_port  out  8  index of the current or last granted port (status)

Behaviour:
- Reset (rst_n low, asynchronous): FSM = IDLE; all outputs 0; rr pointer = 0; all per-port seq counters = 0. A frame in flight is truncated with no tlast, and downstream must tolerate this.
- FSM IDLE: scan tvalid round-robin starting at (last_grant+1) mod N. On any request, register grant = first valid port and go to XFER on the next cycle. Arbitration costs one bubble cycle per frame.
- FSM XFER: combinational pass-through from the granted port.
  - m_axis_tvalid = s_tvalid[g]; s_tready[g] = m_axis_tready; other tready = 0.
  - tdata, tkeep, tlast and tuser[0] are forwarded unchanged.
  - tuser[16:1] = {g[7:0], seq[g]}.
- End of frame: on handshake with tlast=1, seq[g] increments (8-bit, wraps 255 -> 0), last_grant = g, go to IDLE.
- A requester dropping tvalid mid-frame stalls the output. The grant is held and no other port is switched in.
- N=1: grant is always 0; the one-cycle IDLE bubble is kept.
- Timestamp return: s_ptp_ts_valid at cycle t with tag[15:8]=p<N gives m_ptp_ts_valid[p]=1 at t+1 (registered). At the same time m_ptp_ts[p]=s_ptp_ts and m_ptp_ts_tag[p]={8'h00, tag[7:0]}.
  - Tags with p>=N are dropped silently.
  - Per-port ts/tag registers hold their value between strobes.
  - A timestamp strobe coinciding with end-of-frame on the same port is independent; both take effect.
- grant_port updates on entry to XFER and holds through IDLE.

Optional Feature:
ETH_TX_ARB_PTP_TAG_EN
- Defined: behaviour as above (tag rewrite, seq counters, timestamp demux).
- Undefined:
  - m_axis_tuser[16:1] = s_axis_tuser[16:1] of the granted port, unchanged.
  - Seq counters are not built.
  - m_ptp_ts, m_ptp_ts_tag and m_ptp_ts_valid are tied to 0.
  - s_ptp_ts inputs are ignored.

Decomposition:
- Package eth_tx_arb_pkg: FSM state enum {IDLE, XFER}; USER_W=17; TAG_W=16; SEQ_W=8; PORT_TAG_W=8; tag field offsets.
- One sub-module, eth_rr_pick: combinational round-robin priority picker (request vector + pointer -> one-hot/index + valid). It is reused by future RX-side arbiters.

Test Plan:
- N=2, both ports request 3-beat frames continuously -> grants alternate 0,1,0,1. First tags are 0x0000, 0x0100, 0x0001, 0x0101; one idle cycle between frames.
- Port 1 alone sends 256 one-beat frames -> tag low byte runs 0x00..0xFF and the 257th frame carries 0x0100 (wrap).
- m_axis_tready held low 5 cycles mid-frame, and port 0 tvalid drops 2 cycles mid-frame -> no beat lost or duplicated, grant unchanged, s_tready[1]=0 throughout.
- s_ptp_ts_valid with tag 0x0105, ts=0x1234 -> one cycle later m_ptp_ts_valid=2'b10, port 1 ts=0x1234, tag=0x0005. Tag 0x0705 with N=2 -> no strobe on any port.
- rst_n pulsed low mid-frame for one cycle -> all outputs 0 immediately (asynchronous). After release, the next frame from port 0 carries tag 0x0000.
- ETH_TX_ARB_PTP_TAG_EN undefined, port 0 sends tuser=17'h0ABCD -> m_axis_tuser=17'h0ABCD; m_ptp_ts_valid stays 0 under timestamp stimulus.
